// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state type,
// parameter limits and a constant-evaluable ceil(log2) helper.
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int unsigned N_REQ_MIN    = 2;
  localparam int unsigned N_REQ_MAX    = 8;
  localparam int unsigned HOLD_MAX_MIN = 1;

  // ceil(log2(v)); returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     : request vector
//   rr_last : index of the most recent winner
//   any     : at least one request is asserted
//   winner  : first asserted request scanning rr_last+1, rr_last+2, ... (mod N_REQ)
module rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [clog2(N_REQ)-1:0] rr_last,
  output logic                    any,
  output logic [clog2(N_REQ)-1:0] winner
);

  localparam int unsigned RW = clog2(N_REQ);

  // Two passes replace the modulo scan: indices above rr_last first, then wrap.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!any && (i > 32'(rr_last)) && req[i]) begin
        any    = 1'b1;
        winner = RW'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!any && (i <= 32'(rr_last)) && req[i]) begin
        any    = 1'b1;
        winner = RW'(i);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin owner of one shared WIDTH-bit register.
//   CLK, RST_n : clock, asynchronous active-low reset
//   req        : level-sensitive request per requester
//   wr_en      : write strobe per requester
//   wdata      : packed write data, requester i at [i*WIDTH +: WIDTH]
//   grant      : registered one-hot (or zero) ownership
//   q, q_valid : shared register and "written since reset" flag
//   busy       : FSM not IDLE
//   err        : one-cycle pulse, write strobe from a non-owner
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HOLD_MAX = 3
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       wr_en,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       grant,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned    RW        = clog2(N_REQ);
  localparam int unsigned    HW        = clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_MAX);
  localparam logic [RW-1:0]  RR_RESET  = RW'(N_REQ - 1);

  state_e            state_q,    state_d;
  logic [N_REQ-1:0]  grant_q,    grant_d;
  logic [RW-1:0]     rr_last_q,  rr_last_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]  q_q,        q_d;
  logic              q_valid_q,  q_valid_d;
  logic              busy_q,     busy_d;
  logic              err_q,      err_d;

  logic              pick_any;
  logic [RW-1:0]     pick_idx;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .any     (pick_any),
    .winner  (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    hold_cnt_d = hold_cnt_q;
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    err_d      = |(wr_en & ~grant_q);

    // Write path keys off the registered grant, so the final OWN cycle still writes.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i] && wr_en[i]) begin
        q_d       = wdata[i*WIDTH +: WIDTH];
        q_valid_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          rr_last_d         = pick_idx;
          hold_cnt_d        = HW'(1);
          state_d           = OWN;
        end
      end
      OWN: begin
        // rr_last_q is the current owner's index.
        if (!req[rr_last_q] || (hold_cnt_q == HOLD_LAST)) begin
          grant_d    = '0;
          hold_cnt_d = '0;
          state_d    = RELEASE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_last_q  <= RR_RESET;
      hold_cnt_q <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_last_q  <= rr_last_d;
      hold_cnt_q <= hold_cnt_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign grant   = grant_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

  localparam int N_REQ    = 4;
  localparam int WIDTH    = 8;
  localparam int HOLD_MAX = 3;

  logic                   CLK = 1'b0;
  logic                   RST_n = 1'b0;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ-1:0]       wr_en = '0;
  logic [N_REQ*WIDTH-1:0] wdata = '0;
  logic [N_REQ-1:0]       grant;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic                   busy;
  logic                   err;

  shared_reg_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .req     (req),
    .wr_en   (wr_en),
    .wdata   (wdata),
    .grant   (grant),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy),
    .err     (err)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: who owns the register, for how long, and how many
  // quiet cycles remain before the next arbitration.
  int               m_owner;   // -1 = nobody
  int               m_held;
  int               m_cool;
  int               m_last;
  logic [WIDTH-1:0] m_q;
  logic             m_qv;
  logic             m_err;
  logic [N_REQ-1:0] m_g;
  bit               m_found;

  function automatic logic [N_REQ-1:0] model_grant(input int owner);
    logic [N_REQ-1:0] g;
    g = '0;
    if (owner >= 0) g[owner] = 1'b1;
    return g;
  endfunction

  always begin
    @(posedge CLK or negedge RST_n);
    if (!RST_n) begin
      m_owner = -1; m_held = 0; m_cool = 0; m_last = N_REQ - 1;
      m_q = '0; m_qv = 1'b0; m_err = 1'b0;
    end else begin
      m_g   = model_grant(m_owner);
      m_err = |(wr_en & ~m_g);
      if (m_owner >= 0 && wr_en[m_owner]) begin
        m_q  = wdata[m_owner*WIDTH +: WIDTH];
        m_qv = 1'b1;
      end
      if (m_owner >= 0) begin
        if (!req[m_owner] || m_held == HOLD_MAX) begin
          m_owner = -1;
          m_cool  = 1;
        end else begin
          m_held++;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (req != '0) begin
        m_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
          int c;
          c = (m_last + k) % N_REQ;
          if (!m_found && req[c]) begin
            m_found = 1'b1;
            m_owner = c;
            m_last  = c;
            m_held  = 1;
          end
        end
      end
    end
    #1;
    if (chk_en) begin
      check("m_grant",   32'(grant),   32'(model_grant(m_owner)));
      check("m_q",       32'(q),       32'(m_q));
      check("m_q_valid", 32'(q_valid), 32'(m_qv));
      check("m_busy",    32'(busy),    32'((m_owner >= 0) || (m_cool > 0)));
      check("m_err",     32'(err),     32'(m_err));
      check("m_onehot0", 32'($onehot0(grant)), 32'd1);
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    req = '0; wr_en = '0; wdata = '0;
    RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  logic [N_REQ-1:0] exp_rr [20] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0,
                                    4'h2, 4'h2, 4'h2, 4'h0, 4'h0,
                                    4'h4, 4'h4, 4'h4, 4'h0, 4'h0,
                                    4'h8, 4'h8, 4'h8, 4'h0, 4'h0};

  initial begin
    RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    RST_n  = 1'b1;
    chk_en = 1'b1;

    // Reset values
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_q",     32'(q),     32'h0);
    check("rst_busy",  32'(busy),  32'h0);

    // Single requester: grant after one edge, write lands on the next
    do_reset();
    req = 4'b0001; wr_en = 4'b0001; wdata[7:0] = 8'hA5;
    tick();
    check("t1_grant", 32'(grant),   32'h1);
    check("t1_err",   32'(err),     32'h1);
    check("t1_qv0",   32'(q_valid), 32'h0);
    tick();
    check("t1_q",     32'(q),       32'hA5);
    check("t1_qv1",   32'(q_valid), 32'h1);
    check("t1_err0",  32'(err),     32'h0);

    // All requesting: round-robin, HOLD_MAX cycles each, 2-cycle gap
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("t2_rr%0d", i), 32'(grant), 32'(exp_rr[i]));
    end
    tick();
    check("t2_wrap", 32'(grant), 32'h1);

    // Owner 2 writes while requester 1 also strobes
    do_reset();
    req = 4'b0100;
    tick();
    check("t3_grant", 32'(grant), 32'h4);
    @(negedge CLK);
    wr_en = 4'b0110;
    wdata = {8'h00, 8'h22, 8'h11, 8'h00};
    tick();
    check("t3_q",    32'(q),   32'h22);
    check("t3_err",  32'(err), 32'h1);
    @(negedge CLK);
    wr_en = '0;
    tick();
    check("t3_err0", 32'(err), 32'h0);

    // Owner drops request after one OWN cycle
    do_reset();
    req = 4'b0001;
    tick();
    check("t4_grant", 32'(grant), 32'h1);
    @(negedge CLK);
    req = '0;
    tick();
    check("t4_rel_grant", 32'(grant), 32'h0);
    check("t4_rel_busy",  32'(busy),  32'h1);
    tick();
    check("t4_idle_busy", 32'(busy),  32'h0);

    // Asynchronous reset while owning
    do_reset();
    req = 4'b0100;
    tick();
    @(negedge CLK);
    wr_en = 4'b0100; wdata = {8'h00, 8'h5A, 8'h00, 8'h00};
    tick();
    check("t5_qv_pre", 32'(q_valid), 32'h1);
    RST_n = 1'b0;
    #1;
    check("t5_grant", 32'(grant),   32'h0);
    check("t5_q",     32'(q),       32'h0);
    check("t5_qv",    32'(q_valid), 32'h0);
    check("t5_busy",  32'(busy),    32'h0);
    @(negedge CLK);
    wr_en = '0; req = 4'b1111;
    RST_n = 1'b1;
    tick();
    check("t5_first", 32'(grant), 32'h1);

    // Quiet after reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_grant", 32'(grant),   32'h0);
      check("t6_busy",  32'(busy),    32'h0);
      check("t6_err",   32'(err),     32'h0);
      check("t6_qv",    32'(q_valid), 32'h0);
    end

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      for (int b = 0; b < N_REQ; b++) begin
        if ($urandom_range(5) == 0) req[b] = ~req[b];
      end
      wr_en = N_REQ'($urandom & $urandom);
      wdata = (N_REQ*WIDTH)'($urandom);
    end
    @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
